// File: rtl/cpu_tb_pkg.sv
// Shared types for the CPU run monitor: FSM states, result codes and the
// Galois LFSR feedback mask used by the optional clk_enable stall generator.
package cpu_tb_pkg;

    typedef enum logic [1:0] {
        ST_RST_HOLD = 2'd0,
        ST_ARM      = 2'd1,
        ST_RUN      = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE        = 2'd0,
        FC_NO_ACTIVE   = 2'd1,
        FC_TIMEOUT     = 2'd2,
        FC_V0_MISMATCH = 2'd3
    } fail_code_t;

    // x^16 + x^14 + x^13 + x^11, right-shifting Galois form
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
    endfunction

endpackage

// File: rtl/cpu_run_monitor_stall_lfsr.sv
// Pseudo-random clk_enable stall source: stalls when lfsr[1:0]==0, but never
// more than MAX_STALL cycles in a row. Advances only while advance=1.
module stall_lfsr
    import cpu_tb_pkg::*;
#(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          MAX_STALL = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic advance,
    output logic stall
);

    localparam int RUN_W = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);

    logic [15:0]      lfsr;
    logic [RUN_W-1:0] run_cnt;

    assign stall = advance && (lfsr[1:0] == 2'b00) && (run_cnt != RUN_W'(MAX_STALL));

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr    <= SEED;
            run_cnt <= '0;
        end else if (advance) begin
            lfsr    <= lfsr_next(lfsr);
            run_cnt <= stall ? run_cnt + 1'b1 : '0;
        end
    end

endmodule

// File: rtl/cpu_run_monitor.sv
// Run controller for a CPU under test: sequences cpu_reset, waits for active,
// times the run and grades the final register_v0. Optional clk_enable
// throttling is compiled in with CLK_ENABLE_STALL_EN.
module cpu_run_monitor
    import cpu_tb_pkg::*;
#(
    parameter int          RESET_CYCLES       = 2,
    parameter int          ACTIVE_WAIT_CYCLES = 2,
    parameter int          TIMEOUT_CYCLES     = 10000,
    parameter int          CYCLE_W            = 32,
    parameter logic [15:0] LFSR_SEED          = 16'hACE1,
    parameter int          MAX_STALL          = 3
) (
    input  logic               clk,
    input  logic               reset,
    output logic               cpu_reset,
    output logic               cpu_clk_enable,
    input  logic               cpu_active,
    input  logic [31:0]        cpu_register_v0,
    input  logic               check_en,
    input  logic [31:0]        expected_v0,
    output logic               done,
    output logic               pass,
    output logic [1:0]         fail_code,
    output logic [CYCLE_W-1:0] cycle_count,
    output logic [31:0]        v0_final,
    output logic [1:0]         dbg_state
);

    if (RESET_CYCLES < 1 || ACTIVE_WAIT_CYCLES < 1 || LFSR_SEED == 16'h0 || MAX_STALL < 1) begin : g_bad_cfg
        $error("cpu_run_monitor: illegal parameter combination");
    end

    state_t             state_q, state_d;
    fail_code_t         fail_q, fail_d;
    logic [15:0]        hold_q, hold_d;
    logic [15:0]        wait_q, wait_d;
    logic [CYCLE_W-1:0] count_q, count_d, count_inc;
    logic [31:0]        v0_q, v0_d;
    logic               done_q, done_d;
    logic               en_base;

    // Saturating increment: a stuck counter is preferable to a wrapped one.
    assign count_inc = (count_q == '1) ? count_q : count_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        fail_d    = fail_q;
        hold_d    = hold_q;
        wait_d    = wait_q;
        count_d   = count_q;
        v0_d      = v0_q;
        done_d    = done_q;
        cpu_reset = 1'b0;
        en_base   = 1'b0;
        case (state_q)
            ST_RST_HOLD: begin
                cpu_reset = 1'b1;
                if (hold_q == 16'(RESET_CYCLES - 1)) begin
                    state_d = ST_ARM;
                    wait_d  = '0;
                end else begin
                    hold_d = hold_q + 16'd1;
                end
            end
            ST_ARM: begin
                en_base = 1'b1;
                if (cpu_active) begin
                    state_d = ST_RUN;
                end else if (wait_q == 16'(ACTIVE_WAIT_CYCLES - 1)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    fail_d  = FC_NO_ACTIVE;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            ST_RUN: begin
                en_base = 1'b1;
                count_d = count_inc;
                // Active fall is tested first so it beats a coincident timeout.
                if (!cpu_active) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    v0_d    = cpu_register_v0;
                    if (check_en && (cpu_register_v0 != expected_v0))
                        fail_d = FC_V0_MISMATCH;
                end else if (count_inc == CYCLE_W'(TIMEOUT_CYCLES)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    fail_d  = FC_TIMEOUT;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RST_HOLD;
            fail_q  <= FC_NONE;
            hold_q  <= '0;
            wait_q  <= '0;
            count_q <= '0;
            v0_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fail_q  <= fail_d;
            hold_q  <= hold_d;
            wait_q  <= wait_d;
            count_q <= count_d;
            v0_q    <= v0_d;
            done_q  <= done_d;
        end
    end

`ifdef CLK_ENABLE_STALL_EN
    logic advance;
    logic stall;

    // ARM is never throttled: the LFSR only steps and stalls during RUN.
    assign advance = (state_q == ST_RUN);

    stall_lfsr #(
        .SEED      (LFSR_SEED),
        .MAX_STALL (MAX_STALL)
    ) u_stall (
        .clk     (clk),
        .reset   (reset),
        .advance (advance),
        .stall   (stall)
    );

    assign cpu_clk_enable = en_base && !stall;
`else
    assign cpu_clk_enable = en_base;
`endif

    assign done        = done_q;
    assign pass        = done_q && (fail_q == FC_NONE);
    assign fail_code   = fail_q;
    assign cycle_count = count_q;
    assign v0_final    = v0_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Bench for cpu_run_monitor: a bench-driven stub CPU plus a scenario-level
// result model (outcome derived from run length, timeout and v0 rules).
module tb_cpu_run_monitor;

  localparam int RESET_CYCLES = 2;
  localparam int ACTIVE_WAIT  = 2;
  localparam int TIMEOUT      = 100;
  localparam int MAX_STALL    = 3;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_reset, cpu_clk_enable;
  logic        cpu_active = 1'b0;
  logic [31:0] cpu_register_v0 = '0;
  logic        check_en = 1'b0;
  logic [31:0] expected_v0 = '0;
  logic        done, pass;
  logic [1:0]  fail_code;
  logic [31:0] cycle_count, v0_final;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass = 0;
  int obs_streak = 0;
  int max_obs_streak = 0;

`ifdef CLK_ENABLE_STALL_EN
  logic [15:0] m_lfsr;
  int          m_streak;
`endif

  cpu_run_monitor #(
    .RESET_CYCLES       (RESET_CYCLES),
    .ACTIVE_WAIT_CYCLES (ACTIVE_WAIT),
    .TIMEOUT_CYCLES     (TIMEOUT),
    .CYCLE_W            (32),
    .LFSR_SEED          (SEED),
    .MAX_STALL          (MAX_STALL)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .cpu_reset       (cpu_reset),
    .cpu_clk_enable  (cpu_clk_enable),
    .cpu_active      (cpu_active),
    .cpu_register_v0 (cpu_register_v0),
    .check_en        (check_en),
    .expected_v0     (expected_v0),
    .done            (done),
    .pass            (pass),
    .fail_code       (fail_code),
    .cycle_count     (cycle_count),
    .v0_final        (v0_final),
    .dbg_state       (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scenario-level outcome: no active -> NO_ACTIVE; run longer than the
  // timeout -> TIMEOUT at exactly TIMEOUT cycles; otherwise graded on v0.
  task automatic model(input bit rises, input int run_len, input logic [31:0] v0,
                       input logic [31:0] exp, input bit chk,
                       output int e_fail, output int e_count, output logic [31:0] e_v0);
    if (!rises) begin
      e_fail = 1; e_count = 0; e_v0 = '0;
    end else if (run_len > TIMEOUT) begin
      e_fail = 2; e_count = TIMEOUT; e_v0 = '0;
    end else begin
      e_fail = (chk && v0 != exp) ? 3 : 0; e_count = run_len; e_v0 = v0;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    cpu_active = 1'b0;
    @(negedge clk);
    check("rst_ctrl", {26'd0, cpu_reset, cpu_clk_enable, done, pass, fail_code}, 32'b10_0000);
    check("rst_count", cycle_count, 32'd0);
    check("rst_v0", v0_final, 32'd0);
    reset = 1'b0;
`ifdef CLK_ENABLE_STALL_EN
    m_lfsr = SEED;
    m_streak = 0;
`endif
  endtask

  // One complete run. run_len = RUN cycle on whose edge active is sampled low;
  // abort_at > 0 pulses reset at that RUN cycle instead of finishing.
  task automatic do_run(input string name, input bit rises, input int rise_delay,
                        input int run_len, input logic [31:0] v0, input logic [31:0] exp,
                        input bit chk, input int abort_at);
    int k;
    int en_mism;
    int e_fail, e_count;
    logic [31:0] e_v0;
    logic exp_en;
    apply_reset();
    k = 0;
    while (cpu_reset === 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({name, "_hold_len"}, k, RESET_CYCLES);
    check({name, "_arm_en"}, cpu_clk_enable, 1'b1);
    cpu_register_v0 = v0;
    expected_v0 = exp;
    check_en = chk;
    if (!rises) begin
      k = 0;
      while (done !== 1'b1 && k < 20) begin
        @(negedge clk);
        k++;
      end
      check({name, "_noact_lat"}, k, ACTIVE_WAIT);
    end else begin
      repeat (rise_delay) @(negedge clk);
      cpu_active = 1'b1;
      en_mism = 0;
      for (int j = 1; j <= run_len; j++) begin
        @(negedge clk);
        if (done === 1'b1) break;
        if (abort_at > 0 && j == abort_at) begin
          check({name, "_pre_abort_cnt"}, cycle_count, j - 1);
          reset = 1'b1;
          @(negedge clk);
          check({name, "_abort_ctrl"}, {29'd0, cpu_reset, done, pass}, 32'b100);
          check({name, "_abort_cnt"}, cycle_count, 32'd0);
          reset = 1'b0;
          cpu_active = 1'b0;
          return;
        end
`ifdef CLK_ENABLE_STALL_EN
        exp_en = !(m_lfsr[1:0] == 2'b00 && m_streak < MAX_STALL);
        m_streak = exp_en ? 0 : m_streak + 1;
        m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
`else
        exp_en = 1'b1;
`endif
        if (cpu_clk_enable !== exp_en) en_mism++;
      end
      check({name, "_run_en"}, en_mism, 0);
      if (done !== 1'b1) begin
        cpu_active = 1'b0;
        @(negedge clk);
      end
    end
    model(rises, run_len, v0, exp, chk, e_fail, e_count, e_v0);
    check({name, "_done"}, done, 1'b1);
    check({name, "_fail_code"}, fail_code, e_fail);
    check({name, "_pass"}, pass, e_fail == 0);
    check({name, "_count"}, cycle_count, e_count);
    check({name, "_v0_final"}, v0_final, e_v0);
    check({name, "_done_outs"}, {cpu_reset, cpu_clk_enable}, 2'b00);
    // Results must stay frozen even if the CPU keeps toggling.
    cpu_active = 1'b1;
    cpu_register_v0 = ~v0;
    repeat (3) @(negedge clk);
    check({name, "_sticky"}, {done, fail_code, cycle_count[28:0]}, {1'b1, 2'(e_fail), 29'(e_count)});
    cpu_active = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && dbg_state == 2'd2) begin
      obs_streak = cpu_clk_enable ? 0 : obs_streak + 1;
      if (obs_streak > max_obs_streak) max_obs_streak = obs_streak;
    end else begin
      obs_streak = 0;
    end
  end

  initial begin
    logic [31:0] rv0, rexp;
    repeat (2) @(negedge clk);
    do_run("pass_2a", 1'b1, 1, 50, 32'h2A, 32'h2A, 1'b1, 0);
    do_run("mism_2b", 1'b1, 1, 50, 32'h2A, 32'h2B, 1'b1, 0);
    do_run("no_check", 1'b1, 0, 7, 32'h2A, 32'h2B, 1'b0, 0);
    do_run("no_active", 1'b0, 0, 0, 32'h0, 32'h0, 1'b1, 0);
    do_run("timeout", 1'b1, 1, TIMEOUT + 20, 32'h5, 32'h5, 1'b1, 0);
    do_run("fall_at_to", 1'b1, 1, TIMEOUT, 32'h77, 32'h77, 1'b1, 0);
    do_run("fall_before_to", 1'b1, 0, TIMEOUT - 1, 32'h1, 32'h1, 1'b1, 0);
    do_run("short_run", 1'b1, 0, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 0);
    do_run("abort", 1'b1, 1, 50, 32'h2A, 32'h2A, 1'b1, 20);
    do_run("after_abort", 1'b1, 1, 50, 32'h2A, 32'h2A, 1'b1, 0);
    for (int i = 0; i < 12; i++) begin
      rv0 = $urandom;
      rexp = ($urandom_range(0, 1) == 1) ? rv0 : rv0 ^ (32'd1 << $urandom_range(0, 31));
      do_run($sformatf("rand%0d", i), $urandom_range(0, 9) != 0, $urandom_range(0, 1),
             $urandom_range(1, TIMEOUT + 30), rv0, rexp, 1'($urandom_range(0, 1)), 0);
    end
    check("max_stall_run", max_obs_streak <= MAX_STALL, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
